// File: rtl/ex_mdu_if.sv
// ex_mdu_if: request/response bundle between the ID/EX register, the
// multiply/divide unit and the EX/MEM register.
//   Request  : i_valid, o_ready, i_op, i_rs1_data, i_rs2_data, i_rd_idx
//   Control  : i_flush (redirect kill), o_busy (pipeline stall)
//   Response : o_valid, i_ready, o_result, o_rd_idx
// Signal names keep the unit-side direction prefixes.
// slave  = the MDU.
// master = the pipeline driving it.
interface ex_mdu_if #(
  parameter int XLEN    = 64,
  parameter int RADDR_W = 5
);
  logic               i_valid;
  logic               o_ready;
  logic [3:0]         i_op;
  logic [XLEN-1:0]    i_rs1_data;
  logic [XLEN-1:0]    i_rs2_data;
  logic [RADDR_W-1:0] i_rd_idx;
  logic               i_flush;
  logic               o_valid;
  logic               i_ready;
  logic [XLEN-1:0]    o_result;
  logic [RADDR_W-1:0] o_rd_idx;
  logic               o_busy;

  modport slave (
    input  i_valid, i_op, i_rs1_data, i_rs2_data, i_rd_idx, i_flush, i_ready,
    output o_ready, o_valid, o_result, o_rd_idx, o_busy
  );

  modport master (
    output i_valid, i_op, i_rs1_data, i_rs2_data, i_rd_idx, i_flush, i_ready,
    input  o_ready, o_valid, o_result, o_rd_idx, o_busy
  );
endinterface

// File: rtl/ex_mdu.sv
// ex_mdu: multi-cycle RV64M multiply/divide unit for the EX stage.
// Ports:
//   clk  : clock
//   rst  : asynchronous active-high reset
//   bus  : ex_mdu_if.slave
//          - request  : i_valid/o_ready, i_op, i_rs1_data, i_rs2_data, i_rd_idx
//          - control  : i_flush, o_busy
//          - response : o_valid/i_ready, o_result, o_rd_idx
// Datapath:
//   - Shift-add multiply, producing a 2*XLEN product.
//   - Restoring divide on magnitudes.
//   - One radix-2 step per cycle.
//   - 64 steps for full-width ops, 32 for W ops.
// Divide by zero and signed overflow finish directly from IDLE.
// Optional macro MDU_FAST_MUL_EN:
//   - Multiplies are computed combinationally at accept.
//   - Multiplies then finish directly from IDLE.
module ex_mdu #(
  parameter int XLEN    = 64,
  parameter int RADDR_W = 5
) (
  input logic   clk,
  input logic   rst,
  ex_mdu_if.slave bus
);
  localparam int CW = $clog2(XLEN);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         r_state;
  logic [CW-1:0]      r_cnt;
  logic [XLEN-1:0]    r_hi, r_lo, r_m, r_result;
  logic [RADDR_W-1:0] r_rd;
  logic               r_div, r_w, r_rem, r_hisel, r_neg;

  // ---------------- request decode (IDLE) ----------------
  logic [3:0]      w_op;
  logic            w_div, w_w, w_rem, w_sa, w_sb, w_a_neg, w_b_neg;
  logic [31:0]     w_a32n, w_b32n;
  logic [XLEN-1:0] w_an, w_bn, w_a_mag, w_b_mag, w_a_sext;
  logic            w_zero, w_ovf, w_special, w_fast;
  logic [XLEN-1:0] w_spec_res, w_fast_res;

  // Reserved encodings 9-11 behave as MUL.
  assign w_op  = (bus.i_op inside {4'd9, 4'd10, 4'd11}) ? 4'd0 : bus.i_op;
  assign w_div = w_op[2];
  assign w_w   = w_op[3];
  assign w_rem = w_op[1];
  // Operand signedness: MULH signed x signed, MULHSU signed x unsigned.
  // Divides: even opcodes are signed.
  assign w_sa  = w_div ? ~w_op[0] : (w_op == 4'd1 || w_op == 4'd2);
  assign w_sb  = w_div ? ~w_op[0] : (w_op == 4'd1);

  assign w_a_neg = w_sa & (w_w ? bus.i_rs1_data[31] : bus.i_rs1_data[XLEN-1]);
  assign w_b_neg = w_sb & (w_w ? bus.i_rs2_data[31] : bus.i_rs2_data[XLEN-1]);
  assign w_a32n  = 32'd0 - bus.i_rs1_data[31:0];
  assign w_b32n  = 32'd0 - bus.i_rs2_data[31:0];
  assign w_an    = '0 - bus.i_rs1_data;
  assign w_bn    = '0 - bus.i_rs2_data;

  assign w_a_mag = w_w ? {{(XLEN-32){1'b0}}, (w_a_neg ? w_a32n : bus.i_rs1_data[31:0])}
                       : (w_a_neg ? w_an : bus.i_rs1_data);
  assign w_b_mag = w_w ? {{(XLEN-32){1'b0}}, (w_b_neg ? w_b32n : bus.i_rs2_data[31:0])}
                       : (w_b_neg ? w_bn : bus.i_rs2_data);
  assign w_a_sext = {{(XLEN-32){bus.i_rs1_data[31]}}, bus.i_rs1_data[31:0]};

  assign w_zero = w_w ? (bus.i_rs2_data[31:0] == 32'd0) : (bus.i_rs2_data == '0);
  assign w_ovf  = w_div & ~w_op[0] &
                  (w_w ? (bus.i_rs1_data[31:0] == 32'h8000_0000 && bus.i_rs2_data[31:0] == '1)
                       : (bus.i_rs1_data == {1'b1, {(XLEN-1){1'b0}}} && bus.i_rs2_data == '1));
  assign w_special = w_div & (w_zero | w_ovf);

  // Divide-by-zero takes priority; both operands cannot trigger both cases.
  always_comb begin
    w_spec_res = '0;
    if (w_zero)     w_spec_res = w_rem ? (w_w ? w_a_sext : bus.i_rs1_data) : '1;
    else if (w_ovf) w_spec_res = w_rem ? '0 : (w_w ? w_a_sext : bus.i_rs1_data);
  end

`ifdef MDU_FAST_MUL_EN
  logic [2*XLEN-1:0] w_prod_f;
  // Sign-extend each operand to 2*XLEN per its signedness.
  // The modular product then carries the correct signed high half.
  assign w_prod_f = {{XLEN{w_sa & bus.i_rs1_data[XLEN-1]}}, bus.i_rs1_data} *
                    {{XLEN{w_sb & bus.i_rs2_data[XLEN-1]}}, bus.i_rs2_data};
  assign w_fast     = ~w_div;
  assign w_fast_res = w_w ? {{(XLEN-32){w_prod_f[31]}}, w_prod_f[31:0]}
                    : (w_op == 4'd0 ? w_prod_f[XLEN-1:0] : w_prod_f[2*XLEN-1:XLEN]);
`else
  assign w_fast     = 1'b0;
  assign w_fast_res = '0;
`endif

  // ---------------- iteration step (CALC) ----------------
  logic [XLEN:0]   w_msum, w_dsh;
  logic [XLEN-1:0] w_ddiff, w_hi_n, w_lo_n;
  logic            w_dge;

  // Multiply: {hi,lo} shifts right, so the multiplier bits leave lo.
  // The product bits fill in from the top.
  assign w_msum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : '0);
  // Divide: {hi,lo} shifts left, so dividend bits move into the remainder.
  // The quotient bits fill lo from the bottom.
  assign w_dsh   = {r_hi, r_lo[XLEN-1]};
  assign w_dge   = (w_dsh >= {1'b0, r_m});
  assign w_ddiff = w_dsh[XLEN-1:0] - r_m;
  assign w_hi_n  = r_div ? (w_dge ? w_ddiff : w_dsh[XLEN-1:0]) : w_msum[XLEN:1];
  assign w_lo_n  = r_div ? {r_lo[XLEN-2:0], w_dge} : {w_msum[0], r_lo[XLEN-1:1]};

  // ---------------- result formatting ----------------
  logic [2*XLEN-1:0] w_prod_u, w_prod_s;
  logic [XLEN-1:0]   w_mres, w_dval, w_dres;
  logic [31:0]       w_d32, w_d32s;

  assign w_prod_u = {w_hi_n, w_lo_n};
  assign w_prod_s = r_neg ? ('0 - w_prod_u) : w_prod_u;
  // With 32 steps on a zero-extended multiplier, the 32-bit product lands in lo[63:32].
  assign w_mres   = r_w ? {{(XLEN-32){w_lo_n[XLEN-1]}}, w_lo_n[XLEN-1:XLEN-32]}
                  : (r_hisel ? w_prod_s[2*XLEN-1:XLEN] : w_prod_s[XLEN-1:0]);
  assign w_dval   = r_rem ? w_hi_n : w_lo_n;
  assign w_d32    = w_dval[31:0];
  assign w_d32s   = r_neg ? (32'd0 - w_d32) : w_d32;
  assign w_dres   = r_w ? {{(XLEN-32){w_d32s[31]}}, w_d32s}
                  : (r_neg ? ('0 - w_dval) : w_dval);

  // ---------------- control ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_m      <= '0;
      r_result <= '0;
      r_rd     <= '0;
      r_div    <= 1'b0;
      r_w      <= 1'b0;
      r_rem    <= 1'b0;
      r_hisel  <= 1'b0;
      r_neg    <= 1'b0;
    end else if (bus.i_flush) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (bus.i_valid) begin
          r_rd    <= bus.i_rd_idx;
          r_div   <= w_div;
          r_w     <= w_w;
          r_rem   <= w_rem;
          r_hisel <= (w_op != 4'd0);
          r_neg   <= (w_div & w_rem) ? w_a_neg : (w_a_neg ^ w_b_neg);
          r_hi    <= '0;
          r_lo    <= w_div ? (w_w ? {w_a_mag[31:0], 32'd0} : w_a_mag) : w_b_mag;
          r_m     <= w_div ? w_b_mag : w_a_mag;
          r_cnt   <= w_w ? CW'(31) : CW'(XLEN-1);
          if (w_special) begin
            r_result <= w_spec_res;
            r_state  <= S_DONE;
          end else if (w_fast) begin
            r_result <= w_fast_res;
            r_state  <= S_DONE;
          end else begin
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          r_hi <= w_hi_n;
          r_lo <= w_lo_n;
          if (r_cnt == '0) begin
            r_result <= r_div ? w_dres : w_mres;
            r_state  <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DONE: if (bus.i_ready) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_ready  = (r_state == S_IDLE);
  assign bus.o_valid  = (r_state == S_DONE);
  assign bus.o_busy   = (r_state != S_IDLE);
  assign bus.o_result = r_result;
  assign bus.o_rd_idx = r_rd;
endmodule

// File: tb/tb_ex_mdu.sv
module tb_ex_mdu;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  ex_mdu_if #(.XLEN(64), .RADDR_W(5)) bus ();
  ex_mdu #(.XLEN(64), .RADDR_W(5)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] res;
    logic [4:0]  rd;
    int          lat;
  } exp_t;
  exp_t sb[$];

  function automatic logic [63:0] sx32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic logic [63:0] ref_model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [127:0]       p;
    logic signed [63:0] sa, sbv;
    logic [31:0]        a32, b32;
    logic signed [31:0] sa32, sb32;
    logic               ovf64, ovf32;
    sa = a; sbv = b; a32 = a[31:0]; b32 = b[31:0]; sa32 = a32; sb32 = b32;
    ovf64 = (a == 64'h8000_0000_0000_0000) && (b == 64'hFFFF_FFFF_FFFF_FFFF);
    ovf32 = (a32 == 32'h8000_0000) && (b32 == 32'hFFFF_FFFF);
    case (op)
      4'd1: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; return p[127:64]; end
      4'd2: begin p = {{64{a[63]}}, a} * {64'd0, b}; return p[127:64]; end
      4'd3: begin p = {64'd0, a} * {64'd0, b}; return p[127:64]; end
      4'd8: begin p = {64'd0, a} * {64'd0, b}; return sx32(p[31:0]); end
      4'd4: if (b == 0) return '1; else if (ovf64) return a; else return sa / sbv;
      4'd5: if (b == 0) return '1; else return a / b;
      4'd6: if (b == 0) return a; else if (ovf64) return '0; else return sa % sbv;
      4'd7: if (b == 0) return a; else return a % b;
      4'd12: if (b32 == 0) return '1; else if (ovf32) return sx32(a32); else return sx32(sa32 / sb32);
      4'd13: if (b32 == 0) return '1; else return sx32(a32 / b32);
      4'd14: if (b32 == 0) return sx32(a32); else if (ovf32) return '0; else return sx32(sa32 % sb32);
      4'd15: if (b32 == 0) return sx32(a32); else return sx32(a32 % b32);
      default: begin p = {64'd0, a} * {64'd0, b}; return p[63:0]; end
    endcase
  endfunction

  function automatic int ref_lat(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    logic is_w, is_div, zero, ovf;
    is_div = (op >= 4 && op <= 7) || op >= 12;
    is_w   = (op == 8) || op >= 12;
    zero   = is_w ? (b[31:0] == 0) : (b == 0);
    ovf    = !op[0] && (is_w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                             : (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF));
    if (is_div && (zero || ovf)) return 1;
`ifdef MDU_FAST_MUL_EN
    if (!is_div) return 1;
`endif
    return is_w ? 33 : 65;
  endfunction

  task automatic run_op(input string name, input logic [3:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic [4:0] rd, input int hold);
    exp_t e;
    int   cyc;
    e.res = ref_model(op, a, b); e.rd = rd; e.lat = ref_lat(op, a, b);
    sb.push_back(e);
    @(negedge clk);
    bus.i_op = op; bus.i_rs1_data = a; bus.i_rs2_data = b; bus.i_rd_idx = rd;
    bus.i_valid = 1'b1; bus.i_ready = (hold == 0);
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    cyc = 1;
    while (!bus.o_valid && cyc < 200) begin
      // Operands must not matter once accepted.
      bus.i_rs1_data = {$urandom, $urandom};
      bus.i_rs2_data = {$urandom, $urandom};
      bus.i_op       = 4'($urandom);
      bus.i_rd_idx   = 5'($urandom);
      @(posedge clk); #1;
      cyc++;
    end
    e = sb.pop_front();
    checks++;
    if (bus.o_valid !== 1'b1) begin
      errors++; $display("FAIL %s timeout: o_valid=%b after %0d cycles, required 1", name, bus.o_valid, cyc);
    end
    checks++;
    if (cyc !== e.lat) begin
      errors++; $display("FAIL %s latency: got %0d required %0d", name, cyc, e.lat);
    end
    checks++;
    if (bus.o_result !== e.res) begin
      errors++; $display("FAIL %s result: got %h required %h", name, bus.o_result, e.res);
    end
    checks++;
    if (bus.o_rd_idx !== e.rd) begin
      errors++; $display("FAIL %s rd_idx: got %0d required %0d", name, bus.o_rd_idx, e.rd);
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.o_valid !== 1'b1 || bus.o_busy !== 1'b1 || bus.o_ready !== 1'b0 ||
          bus.o_result !== e.res || bus.o_rd_idx !== e.rd) begin
        errors++;
        $display("FAIL %s hold[%0d]: valid=%b busy=%b ready=%b result=%h rd=%0d required 1 1 0 %h %0d",
                 name, i, bus.o_valid, bus.o_busy, bus.o_ready, bus.o_result, bus.o_rd_idx, e.res, e.rd);
      end
    end
    bus.i_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1 || bus.o_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s return_idle: valid=%b ready=%b busy=%b required 0 1 0",
               name, bus.o_valid, bus.o_ready, bus.o_busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1 || bus.o_busy !== 1'b0 ||
        bus.o_result !== 64'd0 || bus.o_rd_idx !== 5'd0) begin
      errors++;
      $display("FAIL reset_state: valid=%b ready=%b busy=%b result=%h rd=%0d required 0 1 0 0 0",
               bus.o_valid, bus.o_ready, bus.o_busy, bus.o_result, bus.o_rd_idx);
    end
    rst = 1'b0;
  endtask

  task automatic test_mul();
    run_op("mul_7x-3", 4'd0, 64'd7, -64'sd3, 5'd5, 0);
    run_op("mulh_neg", 4'd1, -64'sd5, 64'h7FFF_FFFF_FFFF_FFFF, 5'd1, 0);
    run_op("mulhsu", 4'd2, -64'sd2, 64'hFFFF_FFFF_FFFF_FFFF, 5'd2, 0);
    run_op("mulhu", 4'd3, 64'h1234_5678_9ABC_DEF0, 64'hFEDC_BA98_7654_3210, 5'd3, 0);
    run_op("mulw", 4'd8, 64'hAAAA_0000_0001_0001, 64'h5555_0000_FFFF_FFFF, 5'd4, 0);
    run_op("reserved_9", 4'd9, 64'd12345, 64'd678, 5'd6, 0);
  endtask

  task automatic test_div();
    run_op("div_-20_6", 4'd4, -64'sd20, 64'd6, 5'd7, 0);
    run_op("rem_-20_6", 4'd6, -64'sd20, 64'd6, 5'd8, 0);
    run_op("divw_-20_6", 4'd12, 64'h0000_0000_FFFF_FFEC, 64'd6, 5'd9, 0);
    run_op("divuw_sext", 4'd13, 64'h1234_5678_F000_0000, 64'd3, 5'd10, 0);
    run_op("remw_neg", 4'd14, 64'h0000_0000_FFFF_FF9C, 64'hFFFF_FFF9, 5'd11, 0);
    run_op("remuw", 4'd15, 64'hFFFF_FFFF_FFFF_FFF0, 64'd10, 5'd12, 0);
  endtask

  task automatic test_special();
    run_op("divu_by0", 4'd5, 64'd123, 64'd0, 5'd13, 0);
    run_op("remu_by0", 4'd7, 64'd123, 64'd0, 5'd14, 0);
    run_op("div_ovf", 4'd4, 64'h8000_0000_0000_0000, '1, 5'd15, 0);
    run_op("rem_ovf", 4'd6, 64'h8000_0000_0000_0000, '1, 5'd16, 0);
    run_op("divw_by0", 4'd12, 64'd55, 64'hFFFF_FFFF_0000_0000, 5'd17, 0);
    run_op("remw_by0", 4'd14, 64'h0000_0000_8000_0001, 64'd0, 5'd18, 0);
    run_op("divw_ovf", 4'd12, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 5'd19, 0);
  endtask

  task automatic test_stall();
    run_op("stall_divu", 4'd5, 64'd100, 64'd7, 5'd20, 10);
  endtask

  task automatic test_flush();
    logic seen;
    // i_valid together with i_flush in IDLE must be ignored.
    @(negedge clk);
    bus.i_op = 4'd4; bus.i_rs1_data = 64'd9; bus.i_rs2_data = 64'd3;
    bus.i_valid = 1'b1; bus.i_flush = 1'b1;
    @(posedge clk); #1;
    bus.i_valid = 1'b0; bus.i_flush = 1'b0;
    checks++;
    if (bus.o_ready !== 1'b1 || bus.o_busy !== 1'b0) begin
      errors++; $display("FAIL flush_idle_ignore: ready=%b busy=%b required 1 0", bus.o_ready, bus.o_busy);
    end
    @(negedge clk);
    bus.i_op = 4'd4; bus.i_rs1_data = -64'sd1000; bus.i_rs2_data = 64'd7;
    bus.i_rd_idx = 5'd21; bus.i_valid = 1'b1; bus.i_ready = 1'b1;
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    seen = 1'b0;
    repeat (20) begin @(posedge clk); #1; if (bus.o_valid) seen = 1'b1; end
    bus.i_flush = 1'b1;
    @(posedge clk); #1;
    bus.i_flush = 1'b0;
    checks++;
    if (bus.o_ready !== 1'b1 || bus.o_busy !== 1'b0 || bus.o_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_calc: ready=%b busy=%b valid=%b required 1 0 0", bus.o_ready, bus.o_busy, bus.o_valid);
    end
    repeat (70) begin @(posedge clk); #1; if (bus.o_valid) seen = 1'b1; end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL flush_no_valid: o_valid seen=%b required 0", seen);
    end
    run_op("post_flush_mulhu", 4'd3, '1, '1, 5'd22, 0);
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    bus.i_op = 4'd4; bus.i_rs1_data = 64'd12345; bus.i_rs2_data = -64'sd17;
    bus.i_rd_idx = 5'd23; bus.i_valid = 1'b1;
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1 || bus.o_busy !== 1'b0 ||
        bus.o_result !== 64'd0 || bus.o_rd_idx !== 5'd0) begin
      errors++;
      $display("FAIL async_reset: valid=%b ready=%b busy=%b result=%h rd=%0d required 0 1 0 0 0",
               bus.o_valid, bus.o_ready, bus.o_busy, bus.o_result, bus.o_rd_idx);
    end
    @(negedge clk);
    rst = 1'b0;
    run_op("post_reset_rem", 4'd6, 64'd12345, -64'sd17, 5'd24, 0);
  endtask

  task automatic test_random();
    logic [3:0]  op;
    logic [63:0] a, b;
    for (int i = 0; i < 24; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = {$urandom, $urandom};
      b  = ($urandom_range(0, 2) == 0) ? {32'd0, 16'd0, 16'($urandom)} : {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) b = '0;
      run_op($sformatf("rand%0d_op%0d", i, op), op, a, b, 5'($urandom), 0);
    end
  endtask

  initial begin
    bus.i_valid = 1'b0; bus.i_op = '0; bus.i_rs1_data = '0; bus.i_rs2_data = '0;
    bus.i_rd_idx = '0; bus.i_flush = 1'b0; bus.i_ready = 1'b1;
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_stall();
    test_flush();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end
endmodule
